simple_seq: RTL and testbench

Instruction sequencer that sits directly upstream of the combinational `simple` ALU, which it feeds and whose result it consumes. It accepts a byte-wide instruction stream over a valid/ready handshake and holds four 8-bit registers plus carry/zero flags. For each instruction it drives the ALU's `m`, `s`, `a` and `b` inputs from registers, then writes the result back to the register file. A stalling output port exposes register contents to downstream logic.

---
 rtl/simple_pkg.sv | 43 ++++
 rtl/simple_seq_if.sv | 14 +
 rtl/simple_regfile.sv | 35 +++
 rtl/simple_seq.sv | 120 ++++++++++++
 tb/tb_simple_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_pkg.sv
// Shared opcode, ALU control and FSM state definitions for the simple_seq
// instruction sequencer.
package simple_pkg;

  localparam int NREG = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_LDI = 4'd6;
  localparam logic [3:0] OP_OUT = 4'd7;

  typedef struct packed {
    logic       m;
    logic [3:0] s;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD   = '{m: 1'b1, s: 4'b1001};
  localparam alu_ctrl_t ALU_SUB   = '{m: 1'b1, s: 4'b0110};
  localparam alu_ctrl_t ALU_AND   = '{m: 1'b1, s: 4'b1011};
  localparam alu_ctrl_t ALU_NOT   = '{m: 1'b1, s: 4'b0101};
  localparam alu_ctrl_t ALU_PASSA = '{m: 1'b0, s: 4'b1100};
  localparam alu_ctrl_t ALU_PASSB = '{m: 1'b0, s: 4'b1010};
  localparam alu_ctrl_t ALU_IDLE  = '{m: 1'b0, s: 4'b0000};

  typedef enum logic [1:0] {FETCH, IMM, EXEC, OUT} state_t;

  // ALU drive for the register-to-register opcodes; anything else idles the ALU.
  function automatic alu_ctrl_t alu_ctrl(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_NOT:  return ALU_NOT;
      OP_MOV:  return ALU_PASSA;
      default: return ALU_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/simple_seq_if.sv
// Instruction stream and output port handshakes of the simple_seq sequencer.
interface simple_seq_if;
  logic [7:0] instr_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output instr_data, output instr_valid, input instr_ready,
                  input out_data, input out_valid, output out_ready);
  modport slave  (input instr_data, input instr_valid, output instr_ready,
                  output out_data, output out_valid, input out_ready);
endinterface

// File: rtl/simple_regfile.sv
// 4x8 register file: one synchronous write port, three combinational reads
// (Rs, Rd, debug).
module simple_regfile
  import simple_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] rs_addr,
  input  logic [1:0] rd_addr,
  input  logic [1:0] dbg_sel,
  output logic [7:0] rs_data,
  output logic [7:0] rd_data,
  output logic [7:0] dbg_data
);

  logic [7:0] regs [NREG];

  // NOTE: this array is small flops, not a RAM macro, so it is reset like any
  // other state; <= keeps every register update race-free across blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs_data  = regs[rs_addr];
  assign rd_data  = regs[rd_addr];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/simple_seq.sv
// Instruction sequencer feeding the external combinational ALU and writing
// its result back into a 4x8 register file.
module simple_seq
  import simple_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  simple_seq_if.slave bus,
  output logic        alu_m,
  output logic [3:0]  alu_s,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_t,
  input  logic        alu_cf,
  input  logic        alu_zf,
  output logic        cf,
  output logic        zf,
  output logic        err,
  output logic        busy,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  state_t     state;
  alu_ctrl_t  ctrl;
  logic [1:0] ir_rd, ir_rs;
  logic [1:0] rd_addr, rs_addr;
  logic [7:0] rd_data, rs_data;
  logic [3:0] op;
  logic       accept;

  assign op     = bus.instr_data[7:4];
  assign accept = bus.instr_valid && bus.instr_ready;

  // In FETCH the operands come straight from the byte being accepted.
  assign rd_addr = (state == FETCH) ? bus.instr_data[3:2] : ir_rd;
  assign rs_addr = (state == FETCH) ? bus.instr_data[1:0] : ir_rs;

  assign bus.instr_ready = rst_n && ((state == FETCH) || (state == IMM));
  assign busy            = (state != FETCH);
  assign alu_m           = ctrl.m;
  assign alu_s           = ctrl.s;

  simple_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state == EXEC),
    .waddr    (ir_rd),
    .wdata    (alu_t),
    .rs_addr  (rs_addr),
    .rd_addr  (rd_addr),
    .dbg_sel  (dbg_sel),
    .rs_data  (rs_data),
    .rd_data  (rd_data),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FETCH;
      ctrl          <= ALU_IDLE;
      alu_a         <= '0;
      alu_b         <= '0;
      ir_rd         <= '0;
      ir_rs         <= '0;
      cf            <= 1'b0;
      zf            <= 1'b0;
      err           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        FETCH: if (accept) begin
          ir_rd <= bus.instr_data[3:2];
          ir_rs <= bus.instr_data[1:0];
          case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_MOV: begin
              ctrl  <= alu_ctrl(op);
              alu_a <= rs_data;
              alu_b <= rd_data;
              state <= EXEC;
            end
            OP_LDI: state <= IMM;
            OP_OUT: begin
              bus.out_data  <= rd_data;
              bus.out_valid <= 1'b1;
              state         <= OUT;
            end
            default: err <= 1'b1;
          endcase
        end
        IMM: if (accept) begin
          ctrl  <= ALU_PASSB;
          alu_a <= rs_data;
          alu_b <= bus.instr_data;
          state <= EXEC;
        end
        EXEC: begin
          // Only arithmetic updates the flags; logic ops and moves keep them.
          if (ctrl == ALU_ADD || ctrl == ALU_SUB) begin
            cf <= alu_cf;
            zf <= alu_zf;
          end
          ctrl  <= ALU_IDLE;
          alu_a <= '0;
          alu_b <= '0;
          state <= FETCH;
        end
        OUT: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_seq.sv
// Self-checking bench for simple_seq: directed scenarios plus random
// instructions against an instruction-level register/flag model.
module tb_simple_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_m;
  logic [3:0] alu_s;
  logic [7:0] alu_a, alu_b, alu_t;
  logic       alu_cf, alu_zf;
  logic       cf, zf, err, busy;
  logic [1:0] dbg_sel = '0;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_r [4];
  logic       m_cf, m_zf;

  simple_seq_if bus ();

  simple_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_m    (alu_m),
    .alu_s    (alu_s),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_t    (alu_t),
    .alu_cf   (alu_cf),
    .alu_zf   (alu_zf),
    .cf       (cf),
    .zf       (zf),
    .err      (err),
    .busy     (busy),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU stand-in, covering only the modes the sequencer uses.
  // NOTE: every output gets a default first so no latch is implied.
  always_comb begin
    alu_t  = '0;
    alu_cf = 1'b0;
    case ({alu_m, alu_s})
      5'b1_1001: {alu_cf, alu_t} = {1'b0, alu_a} + {1'b0, alu_b};
      5'b1_0110: {alu_cf, alu_t} = {1'b0, alu_b} - {1'b0, alu_a};
      5'b1_1011: alu_t = alu_a & alu_b;
      5'b1_0101: alu_t = ~alu_b;
      5'b0_1100: alu_t = alu_a;
      5'b0_1010: alu_t = alu_b;
      default:   alu_t = '0;
    endcase
    alu_zf = (alu_t == 8'h00);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_cf = 1'b0;
    m_zf = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), {8'h00, dbg_data}, {8'h00, m_r[i]});
    end
    check({tag, "_cf"}, {15'd0, cf}, {15'd0, m_cf});
    check({tag, "_zf"}, {15'd0, zf}, {15'd0, m_zf});
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [7:0] val);
    dbg_sel = 2'(idx);
    #1;
    check(tag, {8'h00, dbg_data}, {8'h00, val});
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.instr_data  = b;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 16'(n >= 50), 16'd0);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  function automatic logic [4:0] exp_ms(input logic [3:0] op);
    case (op)
      4'd1:    return 5'b1_1001;
      4'd2:    return 5'b1_0110;
      4'd3:    return 5'b1_1011;
      4'd4:    return 5'b1_0101;
      4'd5:    return 5'b0_1100;
      default: return 5'b0_0000;
    endcase
  endfunction

  // Issue one instruction (plus immediate for LDI) and check it end to end.
  task automatic do_instr(input logic [7:0] ins, input logic [7:0] imm, input int out_wait);
    logic [3:0] op = ins[7:4];
    int         rd = int'(ins[3:2]);
    int         rs = int'(ins[1:0]);
    logic [8:0] wide;
    logic [7:0] exp_out;
    send(ins);
    case (op)
      4'd0: begin
        @(negedge clk);
        check("nop_busy", {15'd0, busy}, 16'd0);
        check_regs("nop");
      end
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
        @(negedge clk);
        check("exec_ms", {11'd0, alu_m, alu_s}, {11'd0, exp_ms(op)});
        check("exec_a", {8'h00, alu_a}, {8'h00, m_r[rs]});
        check("exec_b", {8'h00, alu_b}, {8'h00, m_r[rd]});
        check("exec_ready", {15'd0, bus.instr_ready}, 16'd0);
        case (op)
          4'd1: begin
            wide = {1'b0, m_r[rd]} + {1'b0, m_r[rs]};
            m_r[rd] = wide[7:0]; m_cf = wide[8]; m_zf = (wide[7:0] == 8'h00);
          end
          4'd2: begin
            wide = {1'b0, m_r[rd]} - {1'b0, m_r[rs]};
            m_r[rd] = wide[7:0]; m_cf = wide[8]; m_zf = (wide[7:0] == 8'h00);
          end
          4'd3:    m_r[rd] = m_r[rd] & m_r[rs];
          4'd4:    m_r[rd] = ~m_r[rd];
          default: m_r[rd] = m_r[rs];
        endcase
        @(negedge clk);
        check("idle_ms", {11'd0, alu_m, alu_s}, 16'd0);
        check("idle_busy", {15'd0, busy}, 16'd0);
        check_regs("alu");
      end
      4'd6: begin
        @(negedge clk);
        check("imm_busy", {15'd0, busy}, 16'd1);
        check("imm_ready", {15'd0, bus.instr_ready}, 16'd1);
        send(imm);
        @(negedge clk);
        check("ldi_ms", {11'd0, alu_m, alu_s}, {11'd0, 5'b0_1010});
        check("ldi_b", {8'h00, alu_b}, {8'h00, imm});
        m_r[rd] = imm;
        @(negedge clk);
        check_regs("ldi");
      end
      4'd7: begin
        exp_out = m_r[rd];
        @(negedge clk);
        for (int i = 0; i < out_wait; i++) begin
          check("out_valid_hold", {15'd0, bus.out_valid}, 16'd1);
          check("out_data_hold", {8'h00, bus.out_data}, {8'h00, exp_out});
          check("out_ready_low", {15'd0, bus.instr_ready}, 16'd0);
          @(negedge clk);
        end
        check("out_valid", {15'd0, bus.out_valid}, 16'd1);
        check("out_data", {8'h00, bus.out_data}, {8'h00, exp_out});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("out_done_valid", {15'd0, bus.out_valid}, 16'd0);
        check("out_done_busy", {15'd0, busy}, 16'd0);
      end
      default: begin
        @(negedge clk);
        check("err_pulse", {15'd0, err}, 16'd1);
        @(negedge clk);
        check("err_clear", {15'd0, err}, 16'd0);
        check_regs("illegal");
      end
    endcase
  endtask

  initial begin
    logic [7:0] ins;
    logic [3:0] op;
    bus.instr_data  = '0;
    bus.instr_valid = 1'b0;
    bus.out_ready   = 1'b0;
    model_reset();

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {15'd0, bus.instr_ready}, 16'd0);
    check("rst_ms", {11'd0, alu_m, alu_s}, 16'd0);
    check("rst_ab", {alu_a, alu_b}, 16'd0);
    check("rst_out", {7'd0, bus.out_valid, bus.out_data}, 16'd0);
    check("rst_err_busy", {14'd0, err, busy}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {15'd0, bus.instr_ready}, 16'd1);
    check_regs("post_rst");

    // ADD overflow, then flag-preserving logic ops.
    do_instr(8'h64, 8'h7F, 0);
    do_instr(8'h68, 8'h81, 0);
    do_instr(8'h16, 8'h00, 0);
    check_reg("add_r1", 1, 8'h00);
    check("add_flags", {14'd0, cf, zf}, 16'd3);
    do_instr(8'h36, 8'h00, 0);
    do_instr(8'h48, 8'h00, 0);
    do_instr(8'h52, 8'h00, 0);
    check_reg("and_r1", 1, 8'h00);
    check_reg("not_r2", 2, 8'h7E);
    check_reg("mov_r0", 0, 8'h7E);
    check("kept_flags", {14'd0, cf, zf}, 16'd3);

    // OUT with five cycles of backpressure.
    do_instr(8'h70, 8'h00, 5);

    // SUB with borrow, then Rd == Rs.
    do_instr(8'h60, 8'h05, 0);
    do_instr(8'h6C, 8'h03, 0);
    do_instr(8'h2C, 8'h00, 0);
    check_reg("sub_r3", 3, 8'hFE);
    check("sub_flags", {14'd0, cf, zf}, 16'd2);
    do_instr(8'h15, 8'h00, 0);

    // Illegal opcode and NOP.
    do_instr(8'hF0, 8'h00, 0);
    do_instr(8'h00, 8'h00, 0);

    // Reset while waiting for an immediate.
    send(8'h64);
    @(negedge clk);
    check("mid_imm_busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_ready", {15'd0, bus.instr_ready}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_reg("abandoned_r1", 1, 8'h00);
    do_instr(8'h70, 8'h00, 0);

    // Random instruction stream.
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 9));
      if (op > 4'd7) op = 4'($urandom_range(8, 15));
      ins = {op, 4'($urandom_range(0, 15))};
      do_instr(ins, 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
